// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM encoding,
// byte width and a constant-friendly clog2.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Host-side write/start bus plus the byte handshake towards SPI_Master.
interface spi_txn_sequencer_if #(
    parameter int LEN_W = 4
) ();

    logic                      i_Wr_DV;
    logic [spi_pkg::BYTE_W-1:0] i_Wr_Byte;
    logic                      o_Wr_Ready;
    logic                      i_Start;
    logic [LEN_W-1:0]          i_Len;
    logic                      o_Busy;
    logic                      o_Done;
    logic                      o_Err;
    logic                      o_M_TX_DV;
    logic [spi_pkg::BYTE_W-1:0] o_M_TX_Byte;
    logic                      i_M_TX_Ready;
    logic                      i_M_RX_DV;
    logic [spi_pkg::BYTE_W-1:0] i_M_RX_Byte;
    logic                      o_Rd_DV;
    logic [spi_pkg::BYTE_W-1:0] o_Rd_Byte;
    logic                      o_SPI_CS_n;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Start, i_Len, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        output o_Wr_Ready, o_Busy, o_Done, o_Err, o_M_TX_DV, o_M_TX_Byte, o_Rd_DV,
               o_Rd_Byte, o_SPI_CS_n
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Start, i_Len, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        input  o_Wr_Ready, o_Busy, o_Done, o_Err, o_M_TX_DV, o_M_TX_Byte, o_Rd_DV,
               o_Rd_Byte, o_SPI_CS_n
    );

endinterface

// File: rtl/spi_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken only when a pop
// frees the slot in the same cycle.
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  pop,
    output logic [BYTE_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Frames a multi-byte SPI transaction around SPI_Master: CS setup, one byte
// per TX/RX handshake, CS hold, with a TX byte FIFO in front.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int LEN_W         = 4,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2
) (
    input logic                i_Clk,
    input logic                i_Rst_L,
    spi_txn_sequencer_if.slave bus
);

    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = clog2(CS_SETUP_CLKS + CS_HOLD_CLKS + 3) + 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_ready_q, wr_ready_d;
    logic                tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                rd_dv_q, rd_dv_d;
    logic [BYTE_W-1:0]   rd_byte_q, rd_byte_d;

    logic                push, pop;
    logic [BYTE_W-1:0]   head;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_cnt, cnt_next;

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (i_Clk),
        .rst_n   (i_Rst_L),
        .push    (push),
        .wr_data (bus.i_Wr_Byte),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign push       = bus.i_Wr_DV & ~fifo_full;
    assign cnt_next   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    assign wr_ready_d = (cnt_next != CNT_W'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        tmr_d     = tmr_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        rd_dv_d   = 1'b0;
        rd_byte_d = rd_byte_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    if (bus.i_Len != '0 && int'(bus.i_Len) <= int'(fifo_cnt)) begin
                        rem_d   = bus.i_Len;
                        tmr_d   = TMR_W'(CS_SETUP_CLKS);
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // The SEND cycle itself supplies the last setup clock before TX_DV.
            ST_SETUP: begin
                if (tmr_q <= TMR_W'(2)) state_d = ST_SEND;
                else                    tmr_d   = tmr_q - TMR_W'(1);
            end
            ST_SEND: begin
                if (bus.i_M_TX_Ready && !fifo_empty) begin
                    pop       = 1'b1;
                    tx_byte_d = head;
                    tx_dv_d   = 1'b1;
                    state_d   = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (bus.i_M_RX_DV) begin
                    rd_byte_d = bus.i_M_RX_Byte;
                    rd_dv_d   = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        tmr_d   = TMR_W'(CS_HOLD_CLKS);
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_q <= TMR_W'(1)) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            tmr_q      <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ready_q <= 1'b1;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            rd_dv_q    <= 1'b0;
            rd_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tmr_q      <= tmr_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ready_q <= wr_ready_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            rd_dv_q    <= rd_dv_d;
            rd_byte_q  <= rd_byte_d;
        end
    end

    assign bus.o_Wr_Ready  = wr_ready_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Done      = done_q;
    assign bus.o_Err       = err_q;
    assign bus.o_M_TX_DV   = tx_dv_q;
    assign bus.o_M_TX_Byte = tx_byte_q;
    assign bus.o_Rd_DV     = rd_dv_q;
    assign bus.o_Rd_Byte   = rd_byte_q;
    assign bus.o_SPI_CS_n  = cs_n_q;

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
Multi-byte SPI transaction controller that sits directly upstream of SPI_Master. It buffers outgoing bytes in a small TX FIFO. On a start request it asserts chip-select, feeds exactly LEN bytes to SPI_Master one at a time over the i_TX_DV/o_TX_Ready handshake, and forwards each received byte. It then releases chip-select after a programmable hold time. This adds the chip-select framing and byte sequencing that SPI_Master lacks.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries (power of two, >= 2)
LEN_W, 4, width of the transaction length field (max LEN = 2^LEN_W - 1)
CS_SETUP_CLKS, 2, i_Clk cycles from CS_n falling to the first TX_DV
CS_HOLD_CLKS, 2, i_Clk cycles from the last RX_DV to CS_n rising

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst_L  in  1  asynchronous, active-low reset
i_Wr_DV  in  1  push i_Wr_Byte into the TX FIFO when o_Wr_Ready=1
i_Wr_Byte  in  8  byte to transmit
o_Wr_Ready  out  1  FIFO not full
i_Start  in  1  one-cycle transaction request
i_Len  in  LEN_W  number of bytes in the transaction
o_Busy  out  1  high from accepted start until o_Done
o_Done  out  1  one-cycle pulse when CS_n returns high
o_Err  out  1  one-cycle pulse when a start is rejected
o_M_TX_DV  out  1  to SPI_Master i_TX_DV
o_M_TX_Byte  out  8  to SPI_Master i_TX_Byte
i_M_TX_Ready  in  1  from SPI_Master o_TX_Ready
i_M_RX_DV  in  1  from SPI_Master o_RX_DV
i_M_RX_Byte  in  8  from SPI_Master o_RX_Byte
o_Rd_DV  out  1  one-cycle pulse, received byte valid
o_Rd_Byte  out  8  received byte
o_SPI_CS_n  out  1  active-low chip select

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, o_SPI_CS_n=1, o_Wr_Ready=1. All other outputs are 0 (o_M_TX_Byte=0, o_Rd_Byte=0).
- All outputs are registered.
- FIFO: push when i_Wr_DV & o_Wr_Ready. A write while full is dropped silently. Simultaneous push and pop is allowed in any state, including when full. Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- IDLE: o_SPI_CS_n=1, o_Busy=0.
  - i_Start with 0 < i_Len <= FIFO count: latch remaining = i_Len, load cnt = CS_SETUP_CLKS, set o_Busy=1, go to SETUP. CS_n falls on the next edge.
  - i_Start with i_Len = 0 or i_Len > count: o_Err=1 for 1 cycle, stay in IDLE.
  - Count is sampled in the same cycle as i_Start; a push in that cycle is not counted.
- SETUP: CS_n=0. Decrement cnt each cycle; at 0 go to SEND. If CS_SETUP_CLKS=0, go to SEND after one cycle.
- SEND: when i_M_TX_Ready=1, pop the FIFO, drive o_M_TX_Byte = head, pulse o_M_TX_DV for exactly 1 cycle, go to WAIT_RX. Never assert TX_DV while i_M_TX_Ready=0.
- WAIT_RX: on i_M_RX_DV, register o_Rd_Byte = i_M_RX_Byte, pulse o_Rd_DV for 1 cycle (1-cycle latency), decrement remaining.
  - remaining becomes 0: load cnt = CS_HOLD_CLKS, go to HOLD.
  - Otherwise go to SEND.
  - TX_DV for the next byte is not issued in the same cycle as RX_DV.
- HOLD: CS_n=0; count down; at 0 set CS_n=1, o_Done=1 for 1 cycle, o_Busy=0, go to IDLE. A new start is accepted in the cycle after o_Done.
- i_Start while o_Busy=1 is ignored: no error, no state change.
- Writes during a transaction are allowed and do not alter remaining.
- Reset mid-transaction immediately forces CS_n=1, flushes the FIFO and aborts with no o_Done. SPI_Master is reset by the same i_Rst_L.
- i_M_RX_DV outside WAIT_RX is ignored.

Decomposition:
- Shared package/header spi_pkg holds:
  - state encodings: IDLE=0, SETUP=1, SEND=2, WAIT_RX=3, HOLD=4 (3 bits)
  - the byte-width constant (8)
  - a clog2 function
- One sub-module, spi_byte_fifo: a synchronous FIFO with push, pop, full, empty and count, parameterised by DEPTH.
- The FSM and counters stay in spi_txn_sequencer.

Test Plan:
1. Reset, then write A5, 3C; start Len=2. SPI_Master model echoes ~TX. Required: CS_n low 2 clks before the first TX_DV; TX bytes A5 then 3C; Rd bytes 5A then C3; CS_n high 2 clks after the second RX_DV; o_Done=1 once; FIFO empty.
2. Write 1 byte, start Len=3 -> o_Err pulses once, CS_n stays 1, byte remains in the FIFO. Then start Len=0 -> o_Err again.
3. Write 9 bytes with depth 8 -> o_Wr_Ready=0 after the 8th, 9th byte dropped. Start Len=8 -> 8 bytes sent in write order, no 9th.
4. Hold i_M_TX_Ready low for 10 clks after SETUP -> no TX_DV until Ready rises, then exactly 1 TX_DV.
5. Start Len=4, then issue i_Start again and 2 writes mid-transaction -> second start ignored with no o_Err; 4 bytes sent; 2 new bytes remain, count=2.
6. Assert i_Rst_L=0 while in WAIT_RX -> CS_n=1 asynchronously before the next edge; FIFO empty; no o_Done; o_Busy=0.
